// File: rtl/sock_arb_pkg.sv
// Shared definitions for the socket channel arbiter: control FSM states,
// default header width and channel-ID header helpers.
package sock_arb_pkg;

    localparam int unsigned HDRW_DEF = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    // Header value for a channel index, truncated by the caller to its width.
    function automatic logic [31:0] hdr_pack(input int unsigned ch);
        return 32'(ch);
    endfunction

    // True when a received header addresses an existing channel.
    function automatic logic hdr_in_range(input logic [31:0] hdr, input int unsigned nch);
        return hdr < nch;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin selector: search starts one past the last granted channel and
// returns the first requester as both a one-hot grant and an index.
module rr_arb #(
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] i_req,
    input  logic [PW-1:0]  i_last,
    output logic [NCH-1:0] o_gnt,
    output logic [PW-1:0]  o_gnt_idx,
    output logic           o_any
);

    int unsigned w_start;
    int unsigned w_best;
    int unsigned w_dist;

    // Distance from the search start decides priority; smallest wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        w_start   = (32'(i_last) + 1 >= NCH) ? 0 : 32'(i_last) + 1;
        w_best    = NCH;
        w_dist    = 0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_dist = (c >= w_start) ? c - w_start : c + NCH - w_start;
            if (i_req[c] && (w_dist < w_best)) begin
                w_best    = w_dist;
                o_gnt     = '0;
                o_gnt[c]  = 1'b1;
                o_gnt_idx = PW'(c);
                o_any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sock_chan_arb.sv
// Multiplexes NCH tagged channels onto one socket word stream and demuxes
// inbound tagged words back to per-channel pulses, with a stop/drain FSM.
module sock_chan_arb
    import sock_arb_pkg::*;
#(
    parameter int unsigned NCH    = 4,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned HDRW   = HDRW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*DWIDTH-1:0]  tx_data,
    input  logic [NCH-1:0]         tx_valid,
    output logic [NCH-1:0]         tx_ready,
    output logic [HDRW+DWIDTH-1:0] sock_din,
    output logic                   sock_din_valid,
    input  logic                   sock_din_ready,
    input  logic [HDRW+DWIDTH-1:0] sock_dout,
    input  logic                   sock_dout_valid,
    output logic [NCH*DWIDTH-1:0]  rx_data,
    output logic [NCH-1:0]         rx_valid,
    input  logic                   stop_req,
    output logic                   socket_nb_condition,
    output logic                   socket_stop,
    output logic [15:0]            rx_err_cnt
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [PW-1:0]            r_last;
    logic [HDRW+DWIDTH-1:0]   r_din;
    logic                     r_dvalid;
    logic [NCH*DWIDTH-1:0]    r_rx_data;
    logic [NCH-1:0]           r_rx_valid;
    logic [15:0]              r_err;

    logic [NCH-1:0]           w_gnt;
    logic [PW-1:0]            w_gidx;
    logic                     w_any;
    logic                     w_can_load;
    logic                     w_open;
    logic                     w_hs;
    logic [DWIDTH-1:0]        w_sel_data;
    logic [HDRW-1:0]          w_hdr;
    logic                     w_hdr_ok;

    rr_arb #(
        .NCH (NCH),
        .PW  (PW)
    ) u_rr_arb (
        .i_req     (tx_valid),
        .i_last    (r_last),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gidx),
        .o_any     (w_any)
    );

    assign w_can_load = !r_dvalid || sock_din_ready;
    assign w_open     = (r_state == ST_RUN) && w_can_load;
    assign tx_ready   = w_gnt & {NCH{w_open}};
    assign w_hs       = w_any && w_open;

    always_comb begin
        w_sel_data = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_gidx == PW'(c)) w_sel_data = tx_data[c*DWIDTH +: DWIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvalid <= 1'b0;
            r_din    <= '0;
            r_last   <= PW'(NCH - 1);
        end else if (w_hs) begin
            r_dvalid <= 1'b1;
            r_din    <= {HDRW'(hdr_pack(32'(w_gidx))), w_sel_data};
            r_last   <= w_gidx;
        end else if (sock_din_ready) begin
            r_dvalid <= 1'b0;
        end
    end

    // DRAIN ends on the cycle the last word drains, so STOPPED follows its handshake directly.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RUN:     if (stop_req) w_next_state = ST_DRAIN;
            ST_DRAIN:   if (!r_dvalid || sock_din_ready) w_next_state = ST_STOPPED;
            ST_STOPPED: w_next_state = ST_STOPPED;
            default:    w_next_state = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next_state;
    end

    assign w_hdr    = sock_dout[DWIDTH +: HDRW];
    assign w_hdr_ok = hdr_in_range(32'(w_hdr), NCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid <= '0;
            r_rx_data  <= '0;
            r_err      <= '0;
        end else begin
            r_rx_valid <= '0;
            if (sock_dout_valid) begin
                if (w_hdr_ok) begin
                    for (int unsigned c = 0; c < NCH; c++) begin
                        if (32'(w_hdr) == c) begin
                            r_rx_valid[c]                  <= 1'b1;
                            r_rx_data[c*DWIDTH +: DWIDTH]  <= sock_dout[DWIDTH-1:0];
                        end
                    end
                end else if (r_err != 16'hFFFF) begin
                    r_err <= r_err + 16'd1;
                end
            end
        end
    end

    assign sock_din            = r_din;
    assign sock_din_valid      = r_dvalid;
    assign rx_data             = r_rx_data;
    assign rx_valid            = r_rx_valid;
    assign rx_err_cnt          = r_err;
    assign socket_stop         = (r_state == ST_STOPPED);
    assign socket_nb_condition = (|tx_valid) | r_dvalid | sock_dout_valid;

endmodule

// File: tb/tb_sock_chan_arb.sv
// Bench for sock_chan_arb: directed scenarios plus random traffic, each cycle
// checked against a behavioural model of the arbiter, demux and stop sequence.
module tb_sock_chan_arb;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned HW  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NCH*DW-1:0] tx_data = '0;
    logic [NCH-1:0]   tx_valid = '0;
    logic [NCH-1:0]   tx_ready;
    logic [HW+DW-1:0] sock_din;
    logic             sock_din_valid;
    logic             sock_din_ready = 1'b0;
    logic [HW+DW-1:0] sock_dout = '0;
    logic             sock_dout_valid = 1'b0;
    logic [NCH*DW-1:0] rx_data;
    logic [NCH-1:0]   rx_valid;
    logic             stop_req = 1'b0;
    logic             socket_nb_condition;
    logic             socket_stop;
    logic [15:0]      rx_err_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: 0 = running, 1 = draining, 2 = stopped
    int          m_last;
    int          m_state;
    bit          m_dvalid;
    logic [39:0] m_din;
    logic [3:0]  m_rxv;
    logic [31:0] m_rxd [4];
    int          m_err;

    sock_chan_arb #(
        .NCH    (NCH),
        .DWIDTH (DW),
        .HDRW   (HW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .sock_din            (sock_din),
        .sock_din_valid      (sock_din_valid),
        .sock_din_ready      (sock_din_ready),
        .sock_dout           (sock_dout),
        .sock_dout_valid     (sock_dout_valid),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .stop_req            (stop_req),
        .socket_nb_condition (socket_nb_condition),
        .socket_stop         (socket_stop),
        .rx_err_cnt          (rx_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last   = NCH - 1;
        m_state  = 0;
        m_dvalid = 1'b0;
        m_din    = '0;
        m_rxv    = '0;
        for (int i = 0; i < 4; i++) m_rxd[i] = '0;
        m_err    = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        chk("rst_din_valid", sock_din_valid, 0);
        chk("rst_din", sock_din, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data_lo", rx_data[63:0], 0);
        chk("rst_rx_data_hi", rx_data[127:64], 0);
        chk("rst_err_cnt", rx_err_cnt, 0);
        chk("rst_socket_stop", socket_stop, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, advance the model,
    // then check registered outputs after the edge.
    task automatic step();
        int         g;
        logic [3:0] exp_txr;
        logic [7:0] h;
        @(negedge clk);
        g = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (g < 0 && tx_valid[c]) g = c;
        end
        exp_txr = (m_state == 0 && (!m_dvalid || sock_din_ready) && g >= 0) ? 4'(1 << g) : 4'd0;
        chk("tx_ready", tx_ready, exp_txr);
        chk("nb_cond", socket_nb_condition, (|tx_valid) || m_dvalid || sock_dout_valid);

        if (exp_txr != 0) begin
            m_din    = {8'(g), tx_data[g*32 +: 32]};
            m_dvalid = 1'b1;
            m_last   = g;
        end else if (sock_din_ready) begin
            m_dvalid = 1'b0;
        end
        if (m_state == 0 && stop_req)      m_state = 1;
        else if (m_state == 1 && !m_dvalid) m_state = 2;

        h     = sock_dout[39:32];
        m_rxv = '0;
        if (sock_dout_valid) begin
            if (h < 4) begin
                m_rxv[h] = 1'b1;
                m_rxd[h] = sock_dout[31:0];
            end else if (m_err < 65535) begin
                m_err++;
            end
        end

        @(posedge clk); #1;
        chk("din_valid", sock_din_valid, m_dvalid);
        if (m_dvalid) chk("din", sock_din, m_din);
        chk("rx_valid", rx_valid, m_rxv);
        for (int i = 0; i < 4; i++) chk($sformatf("rx_data%0d", i), rx_data[i*32 +: 32], m_rxd[i]);
        chk("err_cnt", rx_err_cnt, m_err);
        chk("socket_stop", socket_stop, m_state == 2);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Continuous requests from all channels rotate 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) tx_data[i*32 +: 32] = 32'hA000_0000 + i;
        tx_valid       = 4'hF;
        sock_din_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("hdr_seq", sock_din[39:32], k % 4);
        end

        // Channel 2 word held stable under 5 cycles of backpressure
        tx_valid = 4'b0100;
        tx_data[64 +: 32] = 32'hDEAD_BEEF;
        step();
        chk("ch2_loaded", sock_din, 40'h02_DEAD_BEEF);
        sock_din_ready = 1'b0;
        tx_valid       = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_din", sock_din, 40'h02_DEAD_BEEF);
            chk("hold_txr", tx_ready, 0);
        end
        sock_din_ready = 1'b1;
        tx_valid       = 4'h0;
        step();

        // Inbound delivery to channel 1
        sock_dout       = {8'h01, 32'h1234_5678};
        sock_dout_valid = 1'b1;
        step();
        chk("rx1_valid", rx_valid, 4'b0010);
        chk("rx1_data", rx_data[63:32], 32'h1234_5678);
        sock_dout_valid = 1'b0;
        step();
        chk("rx_pulse_end", rx_valid, 0);

        // Out-of-range headers are dropped and counted
        sock_dout_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sock_dout = {8'h07, $urandom};
            step();
            chk("bad_hdr_rxv", rx_valid, 0);
        end
        sock_dout_valid = 1'b0;
        chk("err_cnt3", rx_err_cnt, 3);

        // Stop with one word pending under 3 cycles of backpressure
        tx_valid       = 4'b0001;
        sock_din_ready = 1'b0;
        step();
        tx_valid = 4'h0;
        stop_req = 1'b1;
        step();
        stop_req = 1'b0;
        tx_valid = 4'hF;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("drain_txr", tx_ready, 0);
            chk("drain_not_stopped", socket_stop, 0);
        end
        sock_din_ready = 1'b1;
        step();
        chk("stopped_after_hs", socket_stop, 1);
        chk("stopped_empty", sock_din_valid, 0);
        sock_dout       = {8'h02, 32'hCAFE_0002};
        sock_dout_valid = 1'b1;
        step();
        chk("rx_in_stopped", rx_valid, 4'b0100);
        sock_dout_valid = 1'b0;

        // Reset while a word is held discards it; channel 0 wins first
        do_reset();
        tx_valid       = 4'hF;
        sock_din_ready = 1'b0;
        step();
        chk("pre_rst_full", sock_din_valid, 1);
        do_reset();
        tx_valid       = 4'h0;
        sock_din_ready = 1'b1;
        step();
        chk("post_rst_empty", sock_din_valid, 0);
        tx_valid = 4'hF;
        step();
        chk("post_rst_ch0", sock_din[39:32], 0);

        // stop_req coinciding with a handshake still emits that word
        tx_valid = 4'b0100;
        stop_req = 1'b1;
        step();
        chk("stop_hs_loaded", sock_din_valid, 1);
        stop_req       = 1'b0;
        sock_din_ready = 1'b0;
        step();
        chk("stop_hs_waiting", socket_stop, 0);
        sock_din_ready = 1'b1;
        step();
        chk("stop_hs_stopped", socket_stop, 1);

        // Random traffic on both directions with occasional stop and reset
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int k = 0; k < 150; k++) begin
                tx_valid = 4'($urandom);
                for (int i = 0; i < 4; i++) tx_data[i*32 +: 32] = $urandom;
                sock_din_ready  = ($urandom % 4) != 0;
                sock_dout_valid = $urandom % 2;
                sock_dout       = {8'($urandom % 6), $urandom};
                stop_req        = ($urandom % 70) == 0;
                step();
            end
            stop_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sock_chan_arb.md
SOCK_CHAN_ARB -- requirements
Module: sock_chan_arb

Interface
REQ-001 Parameter NCH, default 4: number of requester channels, range 2..16.
REQ-002 Parameter DWIDTH, default 32: payload width per channel.
REQ-003 Parameter HDRW, default 8: channel-ID header width; socket word = {header, payload}, header in MSBs.
REQ-004 clk  in  1  clock; reset rst, synchronous, active-high.
REQ-005 tx_data  in  NCH*DWIDTH  per-channel outbound payload, channel i at bits [i*DWIDTH +: DWIDTH].
REQ-006 tx_valid / tx_ready  in / out  NCH  per-channel outbound handshake.
REQ-007 sock_din / sock_din_valid / sock_din_ready  out / out / in  HDRW+DWIDTH, 1, 1  tagged word toward the socket server wrapper.
REQ-008 sock_dout / sock_dout_valid  in / in  HDRW+DWIDTH, 1  tagged word from the socket; no backpressure exists.
REQ-009 rx_data / rx_valid  out / out  NCH*DWIDTH, NCH  demuxed inbound payload, one-cycle valid per word.
REQ-010 stop_req  in  1  single-cycle request to shut the socket down.
REQ-011 socket_nb_condition / socket_stop  out / out  1, 1  socket control.
REQ-012 rx_err_cnt  out  16  count of inbound words with header >= NCH.

Function
REQ-013 Outbound path: single output register; sock_din and sock_din_valid are registered outputs.
REQ-014 Once sock_din_valid=1, sock_din SHALL stay stable until the cycle sock_din_ready=1.
REQ-015 Output register loads when empty or being drained that cycle (valid&ready); throughput one word/cycle under continuous ready.
REQ-016 Arbitration: round-robin among tx_valid; search starts at channel (last_grant+1) mod NCH; after reset last_grant=NCH-1, so channel 0 has first priority.
REQ-017 tx_ready[i]=1 only for the granted channel, only when the output register can load and state is RUN; at most one tx_ready bit high per cycle.
REQ-018 On tx handshake of channel g: sock_din <= {HDRW'(g), tx_data[g]} next cycle; last_grant <= g.
REQ-019 tx_ready is combinational from tx_valid, state and register occupancy; it SHALL NOT depend on sock_din_ready of the same cycle other than via the drain term of REQ-015.
REQ-020 Inbound path: one register stage; a word with header h<NCH produces rx_valid[h]=1 and rx_data[h]=payload exactly one cycle after sock_dout_valid; all other rx_valid bits 0.
REQ-021 Header h>=NCH: word dropped, rx_err_cnt increments by 1, saturating at 16'hFFFF.
REQ-022 Inbound and outbound paths are independent; simultaneous activity on both SHALL NOT stall either.
REQ-023 socket_nb_condition = (|tx_valid) | sock_din_valid | sock_dout_valid, combinational.
REQ-024 Control FSM states RUN, DRAIN, STOPPED.
REQ-025 RUN -> DRAIN on stop_req=1; tx_ready forced 0 from the next cycle.
REQ-026 DRAIN -> STOPPED when the output register is empty (sock_din_valid=0).
REQ-027 STOPPED is terminal until rst; socket_stop=1 only in STOPPED; stop_req ignored outside RUN.
REQ-028 Inbound words keep being delivered in DRAIN and STOPPED.
REQ-029 stop_req in the same cycle as a tx handshake: that handshake completes and is drained before STOPPED.

Reset
REQ-030 During rst: sock_din_valid=0, sock_din=0, rx_valid=0, rx_data=0, rx_err_cnt=0, socket_stop=0, state=RUN, last_grant=NCH-1.
REQ-031 rst mid-transfer discards the output register content; no word is emitted after rst deasserts until a new handshake.

Structure
REQ-032 Shared package sock_arb_pkg holds the FSM state enum, HDRW default and the header pack/unpack functions.
REQ-033 Round-robin selection is a sub-module rr_arb (NCH-wide request in, one-hot grant out, last-grant pointer input).

Verification
REQ-034 All 4 channels tx_valid=1 continuously, sock_din_ready=1 -> sock_din headers 0,1,2,3,0,... one per cycle.
REQ-035 Channel 2 sends 0xDEADBEEF, sock_din_ready=0 for 5 cycles -> sock_din={8'h02,32'hDEADBEEF} held stable for all 5 cycles, all tx_ready=0.
REQ-036 sock_dout={8'h01,32'h12345678} valid 1 cycle -> next cycle rx_valid=4'b0010, rx_data[1]=0x12345678.
REQ-037 sock_dout header 8'h07 three times -> rx_valid stays 0, rx_err_cnt=3.
REQ-038 stop_req with one word pending and sock_din_ready=0 for 3 cycles -> socket_stop rises the cycle after the word's handshake; tx_ready=0 throughout.
REQ-039 rst asserted with sock_din_valid=1 -> after rst sock_din_valid=0, channel 0 granted first.
